// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter: FSM state encoding
// and default word width / baud divider.
package fifo_pkg;

  localparam int unsigned DEF_DATO_WIDTH = 8;
  localparam int unsigned DEF_BAUD_DIV   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_START = 3'd4,
    ST_DATA  = 3'd5,
    ST_STOP  = 3'd6,
    ST_PAR   = 3'd7
  } state_t;

endpackage

// File: rtl/tx_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
module tx_baud_gen
  import fifo_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(BAUD_DIV - 1));

  // Restart on clear or at the end of each bit period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_tx_serializer.sv
// Reads words from an upstream FIFO and sends them as start / LSB-first data /
// stop frames on txd. Define FIFO_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module fifo_tx_serializer
  import fifo_pkg::*;
#(
  parameter int unsigned DATO_WIDTH = DEF_DATO_WIDTH,
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empy,
  input  logic [DATO_WIDTH-1:0] fifo_dat,
  output logic                  rd_strobe,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BIT_CNT_W = $clog2(DATO_WIDTH + 1);

  state_t                state;
  logic [DATO_WIDTH-1:0] shreg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  tick;
  logic                  clear;
`ifdef FIFO_TX_PARITY_EN
  logic                  par;
`endif

  // Baud timer is held clear outside the bit-holding states, so each one starts at 0
  assign clear = !(state inside {ST_START, ST_DATA, ST_PAR, ST_STOP});

  tx_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  // Frame sequencer; txd is registered from the current state so the start
  // bit appears one cycle after START is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      rd_strobe  <= 1'b0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      rd_strobe  <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        ST_START: txd <= 1'b0;
        ST_DATA:  txd <= shreg[0];
`ifdef FIFO_TX_PARITY_EN
        ST_PAR:   txd <= par;
`endif
        default:  txd <= 1'b1;
      endcase

      case (state)
        ST_IDLE: begin
          if (!empy) begin
            state     <= ST_REQ;
            rd_strobe <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_REQ:  state <= ST_WAIT;
        ST_WAIT: state <= ST_LOAD;
        ST_LOAD: begin
          shreg   <= fifo_dat;
          bit_cnt <= '0;
`ifdef FIFO_TX_PARITY_EN
          par     <= ^fifo_dat;
`endif
          state   <= ST_START;
        end
        ST_START: begin
          if (tick) state <= ST_DATA;
        end
        ST_DATA: begin
          if (tick) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(DATO_WIDTH - 1)) begin
`ifdef FIFO_TX_PARITY_EN
              state <= ST_PAR;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef FIFO_TX_PARITY_EN
        ST_PAR: begin
          if (tick) state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          if (tick) begin
            frame_done <= 1'b1;
            if (!empy) begin
              state     <= ST_REQ;
              rd_strobe <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench for fifo_tx_serializer: a small FIFO model feeds a BAUD_DIV=4
// instance; a second BAUD_DIV=2 instance is driven directly for the latency case.
module tb_fifo_tx_serializer;

  localparam int unsigned BD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       empy;
  logic [7:0] fifo_dat = 8'h00;
  logic       rd_strobe, txd, busy, frame_done;

  logic       empy2 = 1'b1;
  logic [7:0] dat2  = 8'h3C;
  logic       rd_strobe2, txd2, busy2, frame_done2;

  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;

  int n_checks = 0;
  int n_err    = 0;
  int n_strobe = 0;
  int n_done   = 0;

  fifo_tx_serializer #(.DATO_WIDTH(8), .BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .empy(empy), .fifo_dat(fifo_dat),
    .rd_strobe(rd_strobe), .txd(txd), .busy(busy), .frame_done(frame_done)
  );

  fifo_tx_serializer #(.DATO_WIDTH(8), .BAUD_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .empy(empy2), .fifo_dat(dat2),
    .rd_strobe(rd_strobe2), .txd(txd2), .busy(busy2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  // FIFO model: datout updates shortly after a clock edge that sees rd_strobe
  assign empy = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (rd_strobe) begin
      #1;
      fifo_dat = mem[rd_ptr];
      rd_ptr   = rd_ptr + 4'd1;
    end
  end

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (rd_strobe)  n_strobe++;
    if (frame_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  // Steps until the start bit shows on txd; expired budget reads as a wrong latency
  task automatic wait_start(input int exp_lat, input string tag);
    int n;
    n = 0;
    while (txd !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(exp_lat));
  endtask

  // Called on the first start-bit cycle; returns one cycle after the stop bit
  task automatic check_frame(input logic [7:0] w, input logic b2b);
    logic [10:0] bits;
    int nb;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = w[i];
`ifdef FIFO_TX_PARITY_EN
    nb       = 11;
    bits[9]  = ^w;
    bits[10] = 1'b1;
`else
    nb      = 10;
    bits[9] = 1'b1;
`endif
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < int'(BD); c++) begin
        chk("txd_bit", 32'(txd), 32'(bits[b]));
        chk("frame_done", 32'(frame_done), 32'((b == nb - 1) && (c == int'(BD) - 1)));
        if (b == nb - 1 && c == int'(BD) - 1) chk("stop_to_req", 32'(rd_strobe), 32'(b2b));
        step();
      end
    end
  endtask

  initial begin
    int s0, d0, bad;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, bad;

    // Reset state
    step(); step(); step();
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(rd_strobe), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Empty hold for 100 clk
    s0  = n_strobe;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("empty_line", 32'(bad), 32'd0);
    chk("empty_strobes", 32'(n_strobe - s0), 32'd0);

    // Single word 0xA5: 0,1,0,1,0,0,1,0,1,1
    s0 = n_strobe;
    d0 = n_done;
    push(8'hA5);
    wait_start(5, "lat_single");
    chk("busy_in_frame", 32'(busy), 32'd1);
    check_frame(8'hA5, 1'b0);
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_txd_after", 32'(txd), 32'd1);
    chk("single_strobes", 32'(n_strobe - s0), 32'd1);
    chk("single_dones", 32'(n_done - d0), 32'd1);

    // Back-to-back 0x01, 0x80, 0xFF with no idle gap
    s0 = n_strobe;
    d0 = n_done;
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    wait_start(5, "lat_b2b0");
    check_frame(8'h01, 1'b1);
    wait_start(3, "lat_b2b1");
    check_frame(8'h80, 1'b1);
    wait_start(3, "lat_b2b2");
    check_frame(8'hFF, 1'b0);
    chk("b2b_strobes", 32'(n_strobe - s0), 32'd3);
    chk("b2b_dones", 32'(n_done - d0), 32'd3);
    chk("b2b_busy_after", 32'(busy), 32'd0);

`ifdef FIFO_TX_PARITY_EN
    // Parity bits: 0x07 -> 1, 0x03 -> 0
    push(8'h07);
    wait_start(5, "lat_par0");
    check_frame(8'h07, 1'b0);
    push(8'h03);
    wait_start(5, "lat_par1");
    check_frame(8'h03, 1'b0);
`endif

    // Latency on the BAUD_DIV=2 instance
    empy2 = 1'b0;
    step();
    chk("lat2_strobe_on", 32'(rd_strobe2), 32'd1);
    empy2 = 1'b1;
    step();
    chk("lat2_strobe_off", 32'(rd_strobe2), 32'd0);
    step(); step();
    chk("lat2_txd_before", 32'(txd2), 32'd1);
    step();
    chk("lat2_txd_start", 32'(txd2), 32'd0);
    repeat (30) step();
    chk("lat2_busy_after", 32'(busy2), 32'd0);

    // Reset mid-DATA of 0xA5 while data bit 1 (a 0) is on the line
    d0 = n_done;
    push(8'hA5);
    wait_start(5, "lat_rst");
    repeat (int'(BD) * 2) step();
    chk("pre_rst_txd", 32'(txd), 32'd0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_strobe", 32'(rd_strobe), 32'd0);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    step(); step();
    rst = 1'b0;
    repeat (60) step();
    chk("post_rst_dones", 32'(n_done - d0), 32'd0);
    chk("post_rst_txd", 32'(txd), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_tx_serializer.md
FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

Interface
REQ-001 Parameter DATO_WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter BAUD_DIV, default 16, SHALL set the clk cycles per serial bit; legal range 2..65535.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 empy  input  1  SHALL carry the upstream FIFO empty flag; 1 means no word available.
REQ-006 fifo_dat  input  DATO_WIDTH  SHALL carry the upstream FIFO read data (its datout).
REQ-007 rd_strobe  output  1  SHALL be the one-cycle read request driven to the FIFO read strobe.
REQ-008 txd  output  1  SHALL be the serial line; idle level 1.
REQ-009 busy  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-010 frame_done  output  1  SHALL pulse high for one clk when a stop bit completes.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, LOAD, START, DATA, STOP (plus PAR when configured).
REQ-012 IDLE: when empy=0 is sampled, the FSM SHALL go to REQ; otherwise it SHALL stay in IDLE with txd=1.
REQ-013 REQ SHALL assert rd_strobe, registered, for exactly one clk, then go to WAIT.
REQ-014 WAIT SHALL last one clk, which allows the FIFO datout to update; LOAD SHALL capture fifo_dat into the shift register.
REQ-015 Latency: the first cycle of the start bit (txd=0) SHALL be 4 clk after the edge that samples empy=0.
REQ-016 START, each DATA bit, PAR and STOP SHALL each hold txd for exactly BAUD_DIV clk, timed by a baud counter that clears on every state entry.
REQ-017 Data bits SHALL be sent LSB first; a bit counter sized ceil(log2(DATO_WIDTH+1)) SHALL count DATO_WIDTH bits and then leave DATA.
REQ-018 STOP SHALL drive txd=1; on its last clk, frame_done SHALL be 1.
REQ-019 After STOP, the FSM SHALL go directly to REQ if empy=0 (back-to-back frames, no idle gap) and to IDLE otherwise.
REQ-020 Changes on empy and fifo_dat outside IDLE/STOP-exit and LOAD respectively SHALL be ignored.
REQ-021 rd_strobe SHALL never assert while empy=1 was the sampled value; there is exactly one strobe per frame.

Reset
REQ-022 While rst=1, the block SHALL force txd=1, rd_strobe=0, busy=0, frame_done=0, state IDLE, and all counters and the shift register to 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously, with no frame_done; the word in progress is lost.
REQ-024 After rst deasserts, the first sample of empy SHALL occur on the first rising clk edge.

Configuration
REQ-025 Macro FIFO_TX_PARITY_EN defined: state PAR SHALL follow DATA and send the even-parity bit (XOR of the data bits) for BAUD_DIV clk; frame = 1+DATO_WIDTH+1+1 bits.
REQ-026 Macro FIFO_TX_PARITY_EN undefined: PAR and its logic SHALL be absent, DATA SHALL go straight to STOP, and frame = DATO_WIDTH+2 bits.

Structure
REQ-027 The shared package fifo_pkg SHALL hold the FSM state encoding constants and the default DATO_WIDTH/BAUD_DIV values.
REQ-028 The baud counter SHALL be a sub-module, tx_baud_gen (inputs clk, rst, clear; output tick on count BAUD_DIV-1).

Verification
REQ-029 Reset: rst=1 mid-DATA of 0xA5 -> txd=1, busy=0, rd_strobe=0 in the same cycle; no frame_done.
REQ-030 Single word: BAUD_DIV=4, empy falls with fifo_dat=0xA5 -> one rd_strobe; txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clk; one frame_done; busy=0 afterwards.
REQ-031 Back-to-back: 3 words 0x01,0x80,0xFF queued, empy=0 throughout -> 3 strobes, 3 frames with no idle gap between the stop bit and the next REQ, 3 frame_done pulses.
REQ-032 Empty hold: empy=1 for 100 clk -> rd_strobe never asserts, txd=1 constant, busy=0.
REQ-033 Parity: with FIFO_TX_PARITY_EN, 0x07 -> parity bit 1; 0x03 -> parity bit 0; frame length 11 bits x BAUD_DIV.
REQ-034 Latency: with BAUD_DIV=2, the start-bit edge SHALL fall exactly 4 clk after empy=0 is sampled in IDLE.
